// File: rtl/rvh_l1d_ar_arb_if.sv
// rvh_l1d_ar_arb_if: AR payload types plus the bank/L2 request and response bundle seen by the arbiter.
package rvh_l1d_ar_pkg;
  typedef struct packed {
    logic [3:0] bid;
    logic [3:0] tid;
  } ar_id_t;
  typedef struct packed {
    ar_id_t      arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
  } cache_mem_if_ar_t;
endpackage

interface rvh_l1d_ar_arb_if
  import rvh_l1d_ar_pkg::*;
#(
  parameter int N_BANK = 2,
  parameter int CNT_W  = 2,
  parameter int BANK_W = $clog2(N_BANK)
);
  logic [N_BANK-1:0]            bank_arvalid_i;
  logic [N_BANK-1:0]            bank_arready_o;
  cache_mem_if_ar_t             bank_ar_i [N_BANK];
  logic                         l2_req_if_arvalid;
  logic                         l2_req_if_arready;
  cache_mem_if_ar_t             l2_req_if_ar;
  logic                         l2_resp_if_rvalid;
  logic                         l2_resp_if_rready;
  logic                         l2_resp_if_rlast;
  logic [BANK_W-1:0]            l2_resp_if_rbid;
  logic [N_BANK-1:0][CNT_W-1:0] bank_outstanding_o;

  modport slave (
    input  bank_arvalid_i, bank_ar_i, l2_req_if_arready,
           l2_resp_if_rvalid, l2_resp_if_rready, l2_resp_if_rlast, l2_resp_if_rbid,
    output bank_arready_o, l2_req_if_arvalid, l2_req_if_ar, bank_outstanding_o
  );
  modport master (
    output bank_arvalid_i, bank_ar_i, l2_req_if_arready,
           l2_resp_if_rvalid, l2_resp_if_rready, l2_resp_if_rlast, l2_resp_if_rbid,
    input  bank_arready_o, l2_req_if_arvalid, l2_req_if_ar, bank_outstanding_o
  );
endinterface

// File: rtl/rvh_l1d_ar_arb.sv
// rvh_l1d_ar_arb: round-robin arbiter sharing the L2 AR channel among L1D banks,
// with a registered output slot and per-bank outstanding-read credit counters.
module rvh_l1d_ar_arb
  import rvh_l1d_ar_pkg::*;
#(
  parameter int N_BANK          = 2,
  parameter int MAX_OUTSTANDING = 3,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1),
  parameter int BANK_W          = $clog2(N_BANK)
) (
  input logic             clk,
  input logic             rst,
  rvh_l1d_ar_arb_if.slave ar
);
  logic              slot_vld;
  cache_mem_if_ar_t  slot_ar;
  logic [BANK_W-1:0] rr_ptr;
  logic [BANK_W-1:0] gnt_idx;
  logic [N_BANK-1:0] eligible;
  logic [N_BANK-1:0] gnt;
  logic              found;
  logic              slot_free;
  logic              r_done;
  logic [CNT_W-1:0]  cnt [N_BANK];

  assign slot_free = ~slot_vld | ar.l2_req_if_arready;
  assign r_done = ar.l2_resp_if_rvalid & ar.l2_resp_if_rready & ar.l2_resp_if_rlast;

  // Eligibility looks only at the registered count, so a refill credit returns one cycle later.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < N_BANK; i++)
      eligible[i] = ar.bank_arvalid_i[i] & (cnt[i] < CNT_W'(MAX_OUTSTANDING));
  end

  always_comb begin
    int idx;
    idx = 0;
    found = 1'b0;
    gnt_idx = '0;
    for (int j = 0; j < N_BANK; j++) begin
      idx = (int'(rr_ptr) + j) % N_BANK;
      if (slot_free && !found && eligible[idx]) begin
        found = 1'b1;
        gnt_idx = BANK_W'(idx);
      end
    end
    gnt = found ? (N_BANK'(1) << gnt_idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_vld <= 1'b0;
      slot_ar <= '0;
      rr_ptr <= '0;
      for (int b = 0; b < N_BANK; b++) cnt[b] <= '0;
    end else begin
      if (found) begin
        slot_vld <= 1'b1;
        slot_ar <= ar.bank_ar_i[gnt_idx];
        rr_ptr <= (gnt_idx == BANK_W'(N_BANK - 1)) ? '0 : gnt_idx + 1'b1;
      end else if (ar.l2_req_if_arready) begin
        slot_vld <= 1'b0;
      end
      for (int b = 0; b < N_BANK; b++) begin
        logic dec;
        dec = r_done && (ar.l2_resp_if_rbid == BANK_W'(b));
        assert (!(dec && cnt[b] == '0));
        if (gnt[b] && !dec) cnt[b] <= cnt[b] + 1'b1;
        else if (dec && !gnt[b]) cnt[b] <= cnt[b] - 1'b1;
      end
    end
  end

  assign ar.bank_arready_o = gnt;
  assign ar.l2_req_if_arvalid = slot_vld;
  assign ar.l2_req_if_ar = slot_ar;

  always_comb begin
    ar.bank_outstanding_o = '0;
    for (int b = 0; b < N_BANK; b++) ar.bank_outstanding_o[b] = cnt[b];
  end
endmodule
